// File: rtl/seq_sipo_deser_pkg.sv
// Shared definitions for the serial-to-parallel deserializer: state encodings,
// state width and a compile-time clog2 helper.
package seq_defs;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/seq_bit_counter.sv
// Bit counter for the deserializer; tc marks the strobe that completes a word.
// With SIPO_PARITY_EN defined, the terminal count moves out by one for the parity bit.
module seq_bit_counter
  import seq_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int CW = clog2(WIDTH + 2);
`ifdef SIPO_PARITY_EN
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == CW'(LAST));

endmodule

// File: rtl/seq_sipo_deser.sv
// Serial-in parallel-out deserializer with valid/ready output, sticky overrun,
// flush, and optional even parity (macro SIPO_PARITY_EN).
module seq_sipo_deser
  import seq_defs::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d_in,
  input  logic             bit_en,
  input  logic             flush,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             clr_ovr,
  output logic             parity_err
);

  // Handshake: a word transfers on the edge where out_valid & out_ready are
  // both high; out_data is stable while out_valid=1 and out_ready while
  // out_valid=0 has no effect.

  state_t           state, state_next;
  logic [WIDTH-1:0] sr, sh_next, word;
  logic             tc, take, drop, complete, handshake, perr_next;

  assign handshake = out_valid & out_ready;
  // A strobe in HOLD is usable only if the held word leaves on the same edge.
  assign take      = bit_en & ~flush & ((state != ST_HOLD) | out_ready);
  assign drop      = bit_en & ~flush & (state == ST_HOLD) & ~out_ready;
  assign complete  = take & tc;

  always_comb begin
    if (MSB_FIRST != 0) begin
      sh_next = (sr << 1) | WIDTH'(d_in);
    end else begin
      sh_next = (sr >> 1) | (WIDTH'(d_in) << (WIDTH - 1));
    end
  end

`ifdef SIPO_PARITY_EN
  // The completing strobe is the parity bit; data is already in sr.
  assign word      = sr;
  assign perr_next = (^sr) ^ d_in;
`else
  assign word      = sh_next;
  assign perr_next = 1'b0;
`endif

  seq_bit_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (flush | complete),
    .inc  (take & ~tc),
    .tc   (tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = ST_IDLE;
    end else if (take) begin
      state_next = tc ? ST_HOLD : ST_SHIFT;
    end else if ((state == ST_HOLD) && handshake) begin
      state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (flush || complete) begin
        sr <= '0;
      end else if (take) begin
        sr <= sh_next;
      end
      if (!flush && complete) begin
        out_data <= word;
      end
      if (flush) begin
        out_valid <= 1'b0;
      end else if (complete) begin
        out_valid <= 1'b1;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_ovr) begin
      overrun <= 1'b0;
    end
  end

`ifdef SIPO_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      parity_err <= 1'b0;
    end else if (complete) begin
      parity_err <= perr_next;
    end else if (handshake) begin
      parity_err <= 1'b0;
    end
  end
`else
  assign parity_err = perr_next;
`endif

endmodule

// File: tb/tb_seq_sipo_deser.sv
// Directed bench for seq_sipo_deser: one MSB-first and one LSB-first instance
// share stimulus; parity steps are active when SIPO_PARITY_EN is defined.
module tb_seq_sipo_deser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       d_in = 1'b0;
  logic       bit_en = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic       clr_ovr = 1'b0;
  logic [7:0] m_data, l_data;
  logic       m_valid, l_valid, m_ovr, l_ovr, m_perr, l_perr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_sipo_deser #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst_n(rst_n), .d_in(d_in), .bit_en(bit_en), .flush(flush),
    .out_data(m_data), .out_valid(m_valid), .out_ready(out_ready),
    .overrun(m_ovr), .clr_ovr(clr_ovr), .parity_err(m_perr)
  );

  seq_sipo_deser #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst_n(rst_n), .d_in(d_in), .bit_en(bit_en), .flush(flush),
    .out_data(l_data), .out_valid(l_valid), .out_ready(out_ready),
    .overrun(l_ovr), .clr_ovr(clr_ovr), .parity_err(l_perr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic b);
    bit_en = 1'b1;
    d_in   = b;
    tick(1);
    bit_en = 1'b0;
    d_in   = 1'b0;
  endtask

  // Sends v[7] first; in parity builds appends the parity bit (even, or odd if bad).
  task automatic send_word(input logic [7:0] v, input logic bad);
    for (int i = 7; i >= 0; i--) strobe(v[i]);
`ifdef SIPO_PARITY_EN
    strobe((^v) ^ bad);
`else
    if (bad) $display("note: parity request ignored in this build");
`endif
  endtask

  initial begin
    // Reset
    tick(2);
    check("rst_data", {24'd0, m_data}, 32'h00);
    check("rst_valid", {31'd0, m_valid}, 32'd0);
    check("rst_ovr", {31'd0, m_ovr}, 32'd0);
    check("rst_perr", {31'd0, m_perr}, 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Basic word with out_ready high: valid for exactly one cycle
    out_ready = 1'b1;
    send_word(8'b1010_0101, 1'b0);
    check("basic_valid", {31'd0, m_valid}, 32'd1);
    check("basic_data_m", {24'd0, m_data}, 32'hA5);
    check("basic_data_l", {24'd0, l_data}, 32'hA5);
    check("basic_perr", {31'd0, m_perr}, 32'd0);
    tick(1);
    check("basic_valid_drop", {31'd0, m_valid}, 32'd0);

    // Bit order
    send_word(8'b1100_0000, 1'b0);
    check("order_data_m", {24'd0, m_data}, 32'hC0);
    check("order_data_l", {24'd0, l_data}, 32'h03);
    tick(1);

    // Back-pressure with drops in HOLD; set beats simultaneous clear
    out_ready = 1'b0;
    send_word(8'h3C, 1'b0);
    check("bp_valid", {31'd0, m_valid}, 32'd1);
    tick(1);
    strobe(1'b1);
    check("bp_ovr_set", {31'd0, m_ovr}, 32'd1);
    clr_ovr = 1'b1;
    strobe(1'b0);
    clr_ovr = 1'b0;
    check("bp_set_wins", {31'd0, m_ovr}, 32'd1);
    tick(1);
    check("bp_hold_data", {24'd0, m_data}, 32'h3C);
    check("bp_hold_valid", {31'd0, m_valid}, 32'd1);
    check("bp_hold_data_l", {24'd0, l_data}, 32'h3C);
    out_ready = 1'b1;
    tick(1);
    check("bp_accept", {31'd0, m_valid}, 32'd0);
    check("bp_ovr_sticky", {31'd0, m_ovr}, 32'd1);
    clr_ovr = 1'b1;
    tick(1);
    clr_ovr = 1'b0;
    check("bp_ovr_clr", {31'd0, m_ovr}, 32'd0);

    // Handshake and strobe on the same edge: bit starts the next word
    out_ready = 1'b0;
    send_word(8'h55, 1'b0);
    check("sim_first", {24'd0, m_data}, 32'h55);
    out_ready = 1'b1;
    strobe(1'b1);
    check("sim_no_ovr", {31'd0, m_ovr}, 32'd0);
    check("sim_valid_low", {31'd0, m_valid}, 32'd0);
    for (int i = 0; i < 7; i++) strobe(1'b0);
`ifdef SIPO_PARITY_EN
    strobe(1'b1);
`endif
    check("sim_valid", {31'd0, m_valid}, 32'd1);
    check("sim_data_m", {24'd0, m_data}, 32'h80);
    check("sim_data_l", {24'd0, l_data}, 32'h01);
    tick(1);

    // Flush mid-word
    strobe(1'b1);
    strobe(1'b0);
    strobe(1'b1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    check("flush_valid", {31'd0, m_valid}, 32'd0);
    send_word(8'hFF, 1'b0);
    check("flush_data_m", {24'd0, m_data}, 32'hFF);
    check("flush_data_l", {24'd0, l_data}, 32'hFF);
    tick(1);

    // Flush a held word: data holds, valid drops, overrun untouched
    out_ready = 1'b0;
    send_word(8'h96, 1'b0);
    strobe(1'b1);
    check("hflush_ovr_pre", {31'd0, m_ovr}, 32'd1);
    flush = 1'b1;
    bit_en = 1'b1;
    tick(1);
    flush = 1'b0;
    bit_en = 1'b0;
    check("hflush_valid", {31'd0, m_valid}, 32'd0);
    check("hflush_data", {24'd0, m_data}, 32'h96);
    check("hflush_ovr", {31'd0, m_ovr}, 32'd1);

    // Reset after 5 bits discards everything
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) strobe(1'b1);
    rst_n = 1'b0;
    tick(1);
    check("mrst_data", {24'd0, m_data}, 32'h00);
    check("mrst_valid", {31'd0, m_valid}, 32'd0);
    check("mrst_ovr", {31'd0, m_ovr}, 32'd0);
    check("mrst_perr", {31'd0, m_perr}, 32'd0);
    rst_n = 1'b1;
    tick(1);
    send_word(8'h5A, 1'b0);
    check("post_rst_m", {24'd0, m_data}, 32'h5A);
    check("post_rst_l", {24'd0, l_data}, 32'h5A);
    check("post_rst_valid", {31'd0, l_valid}, 32'd1);
    tick(1);

`ifdef SIPO_PARITY_EN
    out_ready = 1'b0;
    send_word(8'hA5, 1'b0);
    check("par_good_valid", {31'd0, m_valid}, 32'd1);
    check("par_good_err", {31'd0, m_perr}, 32'd0);
    check("par_good_data", {24'd0, m_data}, 32'hA5);
    out_ready = 1'b1;
    tick(1);
    send_word(8'hA5, 1'b1);
    check("par_bad_valid", {31'd0, m_valid}, 32'd1);
    check("par_bad_err", {31'd0, m_perr}, 32'd1);
    check("par_bad_err_l", {31'd0, l_perr}, 32'd1);
    tick(1);
    check("par_clear", {31'd0, m_perr}, 32'd0);
`else
    check("noparity_tie", {31'd0, l_perr}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
